// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: the processor core (C)
// and the host loader/dumper (H) share the memory with round-robin priority,
// a bounded burst length, registered read return and a saturating stall
// counter for performance checks.
module dmem_arbiter #(
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  // core port
  input  logic          c_req_i,
  input  logic          c_we_i,
  input  logic [AW-1:0] c_addr_i,
  input  logic [DW-1:0] c_wdata_i,
  output logic          c_gnt_o,
  output logic          c_rvalid_o,
  output logic [DW-1:0] c_rdata_o,
  // host port
  input  logic          h_req_i,
  input  logic          h_we_i,
  input  logic [AW-1:0] h_addr_i,
  input  logic [DW-1:0] h_wdata_i,
  output logic          h_gnt_o,
  output logic          h_rvalid_o,
  output logic [DW-1:0] h_rdata_o,
  // memory side
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  // performance
  output logic [15:0]   stall_cnt_o
);

  typedef enum logic [1:0] {OWN_NONE, OWN_C, OWN_H} owner_e;
  typedef enum logic {LAST_C, LAST_H} last_e;

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);

  owner_e        owner_q, owner_d, winner;
  last_e         last_q, last_d;
  logic [3:0]    burst_q, burst_d;
  logic          c_rvalid_q, h_rvalid_q;
  logic [DW-1:0] c_rdata_q, h_rdata_q;
  logic [15:0]   stall_q;
  logic          stall_event;

  // Ownership state register; last starts at H so C wins the first contention
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      last_q  <= LAST_H;
      burst_q <= 4'd0;
    end else begin
      owner_q <= owner_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

  // Pick this cycle's winner from registered ownership and live requests;
  // holding reset suppresses any grant so an aborted access stops at once
  always_comb begin
    winner = OWN_NONE;
    if (!rst_n) begin
      winner = OWN_NONE;
    end else if (c_req_i && h_req_i) begin
      case (owner_q)
        OWN_C:   winner = (burst_q < MaxBurst) ? OWN_C : OWN_H;
        OWN_H:   winner = (burst_q < MaxBurst) ? OWN_H : OWN_C;
        default: winner = (last_q == LAST_H) ? OWN_C : OWN_H;
      endcase
    end else if (c_req_i) begin
      winner = OWN_C;
    end else if (h_req_i) begin
      winner = OWN_H;
    end
  end

  // Next ownership, burst length and round-robin pointer
  always_comb begin
    owner_d = winner;
    last_d  = last_q;
    burst_d = burst_q;
    if (winner == OWN_NONE) begin
      burst_d = 4'd0;
    end else begin
      last_d = (winner == OWN_C) ? LAST_C : LAST_H;
      if (winner == owner_q) begin
        burst_d = (burst_q < MaxBurst) ? burst_q + 4'd1 : MaxBurst;
      end else begin
        burst_d = 4'd1;
      end
    end
  end

  // Grants and memory mux: the winner's request drives the memory directly
  always_comb begin
    c_gnt_o     = 1'b0;
    h_gnt_o     = 1'b0;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    if (winner == OWN_C) begin
      c_gnt_o     = 1'b1;
      mem_addr_o  = c_addr_i;
      mem_we_o    = c_we_i;
      mem_wdata_o = c_wdata_i;
    end else if (winner == OWN_H) begin
      h_gnt_o     = 1'b1;
      mem_addr_o  = h_addr_i;
      mem_we_o    = h_we_i;
      mem_wdata_o = h_wdata_i;
    end
  end

  // Capture read data for a granted read; rdata keeps its value otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_rvalid_q <= 1'b0;
      h_rvalid_q <= 1'b0;
      c_rdata_q  <= '0;
      h_rdata_q  <= '0;
    end else begin
      c_rvalid_q <= c_gnt_o && !c_we_i;
      h_rvalid_q <= h_gnt_o && !h_we_i;
      if (c_gnt_o && !c_we_i) c_rdata_q <= mem_rdata_i;
      if (h_gnt_o && !h_we_i) h_rdata_q <= mem_rdata_i;
    end
  end

  assign stall_event = (c_req_i && !c_gnt_o) || (h_req_i && !h_gnt_o);

  // Count cycles where some requester waited; stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= 16'd0;
    end else if (stall_event && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign c_rvalid_o  = c_rvalid_q;
  assign h_rvalid_o  = h_rvalid_q;
  assign c_rdata_o   = c_rdata_q;
  assign h_rdata_o   = h_rdata_q;
  assign stall_cnt_o = stall_q;

endmodule
